// File: rtl/priority_encoder_4_2_pkg.sv
// Shared widths and FSM encodings for the 4-to-2 request encoder.
package priority_encoder_4_2_pkg;
    localparam int NUM_REQ = 4;
    localparam int CODE_W  = 2;
    localparam int CNT_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;
endpackage

// File: rtl/priority_encoder_4_2_pick.sv
// Combinational selector: highest set bit, or first set bit after rr_last when rr_en.
module pick_4_2
    import priority_encoder_4_2_pkg::*;
(
    input  logic [NUM_REQ-1:0] mask,
    input  logic [CODE_W-1:0]  rr_last,
    input  logic               rr_en,
    output logic [CODE_W-1:0]  idx
);
    logic [CODE_W-1:0] j;

    always_comb begin
        idx = '0;
        j   = '0;
        if (!rr_en) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (mask[i]) idx = i[CODE_W-1:0];
            end
        end else begin
            // Scan offsets from farthest to nearest so the nearest set bit wins.
            for (int unsigned k = NUM_REQ; k >= 1; k--) begin
                j = rr_last + k[CODE_W-1:0];
                if (mask[j]) idx = j;
            end
        end
    end
endmodule

// File: rtl/priority_encoder_4_2.sv
// Sequential 4-to-2 request encoder: pending register, valid/ready offer FSM, popcount.
module priority_encoder_4_2
    import priority_encoder_4_2_pkg::*;
#(
    parameter int ROUND_ROBIN = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ready,
    output logic [CODE_W-1:0]  code,
    output logic               valid,
    output logic [NUM_REQ-1:0] pending,
    output logic [CNT_W-1:0]   pending_cnt
);
    state_t              state;
    logic [NUM_REQ-1:0]  p;
    logic [CODE_W-1:0]   code_r;
    logic                valid_r;
    logic [CODE_W-1:0]   rr_last;

    logic                accept;
    logic [NUM_REQ-1:0]  acc_mask;
    logic [NUM_REQ-1:0]  rem;
    logic [CODE_W-1:0]   pick_rr;
    logic [CODE_W-1:0]   pick_idx;

    assign accept   = valid_r && ready;
    assign acc_mask = accept ? (4'b0001 << code_r) : '0;
    // In IDLE acc_mask is zero, so rem == p and one selector serves both load paths.
    assign rem      = p & ~acc_mask;
    assign pick_rr  = accept ? code_r : rr_last;

    pick_4_2 u_pick (
        .mask    (rem),
        .rr_last (pick_rr),
        .rr_en   (ROUND_ROBIN != 0),
        .idx     (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            p       <= '0;
            code_r  <= '0;
            valid_r <= 1'b0;
            rr_last <= 2'd3;
        end else begin
            p <= rem | req;
            if (accept) rr_last <= code_r;
            case (state)
                ST_IDLE: begin
                    if (p != '0) begin
                        code_r  <= pick_idx;
                        valid_r <= 1'b1;
                        state   <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (ready) begin
                        if (rem != '0) begin
                            code_r <= pick_idx;
                        end else begin
                            valid_r <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pending_cnt = pending_cnt + {{(CNT_W-1){1'b0}}, p[i]};
        end
    end

    assign code    = code_r;
    assign valid   = valid_r;
    assign pending = p;
endmodule
